// File: rtl/seg_serial_receiver.sv
// Serial seven-segment receiver: synchronises lane/shift inputs, reassembles one
// 8-bit pattern per digit MSB-first, and decodes each pattern back to BCD.
module seg_serial_receiver #(
   parameter int unsigned DIGITS      = 3,
   parameter int unsigned IDLE_CYCLES = 64,
   parameter int unsigned IDLE_W      = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DIGITS-1:0]     seg_in,
   input  logic                  shift_in,
   output logic [8*DIGITS-1:0]   seg_out,
   output logic [4*DIGITS-1:0]   cnt_out,
   output logic [DIGITS-1:0]     digit_ok,
   output logic                  frame_valid,
   output logic                  frame_err
);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t                   state;
   logic                     shift_meta, shift_sync, shift_prev;
   logic [DIGITS-1:0]        seg_meta, seg_sync;
   logic [DIGITS-1:0][7:0]   sreg;
   logic [3:0]               bit_cnt;
   logic [IDLE_W-1:0]        idle_cnt;
   logic                     rise;
   logic [4*DIGITS-1:0]      dec_cnt;
   logic [DIGITS-1:0]        dec_ok;

   // {ok, bcd}; dp (bit7) is ignored by the caller
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h3F:   decode = {1'b1, 4'd0};
         7'h06:   decode = {1'b1, 4'd1};
         7'h5B:   decode = {1'b1, 4'd2};
         7'h4F:   decode = {1'b1, 4'd3};
         7'h66:   decode = {1'b1, 4'd4};
         7'h6D:   decode = {1'b1, 4'd5};
         7'h7D:   decode = {1'b1, 4'd6};
         7'h07:   decode = {1'b1, 4'd7};
         7'h7F:   decode = {1'b1, 4'd8};
         7'h6F:   decode = {1'b1, 4'd9};
         default: decode = {1'b0, 4'hF};
      endcase
   endfunction

   always_comb begin
      dec_cnt = '1;
      dec_ok  = '0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         {dec_ok[j], dec_cnt[4*j +: 4]} = decode(sreg[j][6:0]);
      end
   end

   assign rise = shift_sync & ~shift_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_meta <= 1'b0;
         shift_sync <= 1'b0;
         shift_prev <= 1'b0;
         seg_meta   <= '0;
         seg_sync   <= '0;
      end else begin
         shift_meta <= shift_in;
         shift_sync <= shift_meta;
         shift_prev <= shift_sync;
         seg_meta   <= seg_in;
         seg_sync   <= seg_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         sreg        <= '0;
         seg_out     <= '0;
         cnt_out     <= '0;
         digit_ok    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (rise && state != LATCH) begin
            for (int unsigned j = 0; j < DIGITS; j++) begin
               sreg[j] <= {sreg[j][6:0], seg_sync[j]};
            end
         end
         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= SHIFT;
                  bit_cnt  <= 4'd1;
                  idle_cnt <= '0;
               end
            end
            SHIFT: begin
               // an edge in the timeout cycle keeps the frame alive
               if (rise) begin
                  idle_cnt <= '0;
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) state <= LATCH;
               end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  idle_cnt  <= '0;
                  sreg      <= '0;
                  frame_err <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            LATCH: begin
               seg_out     <= sreg;
               cnt_out     <= dec_cnt;
               digit_ok    <= dec_ok;
               frame_valid <= 1'b1;
               bit_cnt     <= '0;
               idle_cnt    <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_serial_receiver.sv
// Directed bench for seg_serial_receiver: sends MSB-first frames on three lanes
// and checks decoded outputs, pulse counts and timeout timing.
module tb_seg_serial_receiver;

   localparam int unsigned DIGITS = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [DIGITS-1:0]     seg_in;
   logic                  shift_in;
   logic [8*DIGITS-1:0]   seg_out;
   logic [4*DIGITS-1:0]   cnt_out;
   logic [DIGITS-1:0]     digit_ok;
   logic                  frame_valid;
   logic                  frame_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int err_cyc = 0;
   int last_rise = 0;

   seg_serial_receiver #(.DIGITS(DIGITS), .IDLE_CYCLES(64), .IDLE_W(7)) dut (
      .clk(clk), .reset(reset), .seg_in(seg_in), .shift_in(shift_in),
      .seg_out(seg_out), .cnt_out(cnt_out), .digit_ok(digit_ok),
      .frame_valid(frame_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) fv_cnt++;
      if (frame_err) begin
         fe_cnt++;
         err_cyc = cyc;
      end
      if (frame_valid && frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // one bit per lane: data set 1 clk before the rising edge, high 4 clk, low lo clk
   task automatic send_bits(input logic [8*DIGITS-1:0] pat, input int nbits, input int lo);
      for (int i = 0; i < nbits; i++) begin
         for (int j = 0; j < DIGITS; j++) seg_in[j] = pat[8*j + 7 - i];
         tick(1);
         shift_in  = 1'b1;
         last_rise = cyc;
         tick(4);
         shift_in  = 1'b0;
         tick(lo);
      end
   endtask

   task automatic clear_counts();
      fv_cnt = 0;
      fe_cnt = 0;
   endtask

   initial begin
      reset    = 1'b1;
      seg_in   = '0;
      shift_in = 1'b0;
      tick(3);
      check("rst_seg", 32'(seg_out), 32'h0);
      check("rst_cnt", 32'(cnt_out), 32'h0);
      reset = 1'b0;
      clear_counts();
      tick(200);
      check("idle_seg", 32'(seg_out), 32'h0);
      check("idle_cnt", 32'(cnt_out), 32'h0);
      check("idle_ok", 32'(digit_ok), 32'h0);
      check("idle_fv", 32'(fv_cnt), 32'd0);
      check("idle_fe", 32'(fe_cnt), 32'd0);

      // basic frame: digits 3,1,0
      clear_counts();
      send_bits(24'h3F064F, 8, 4);
      tick(10);
      check("f1_fv", 32'(fv_cnt), 32'd1);
      check("f1_seg", 32'(seg_out), 32'h3F064F);
      check("f1_cnt", 32'(cnt_out), 32'h013);
      check("f1_ok", 32'(digit_ok), 32'h7);

      // dp set on digit1 is masked by decode
      clear_counts();
      send_bits(24'h3F864F, 8, 4);
      tick(10);
      check("dp_fv", 32'(fv_cnt), 32'd1);
      check("dp_seg1", 32'(seg_out[15:8]), 32'h86);
      check("dp_cnt", 32'(cnt_out), 32'h013);
      check("dp_ok", 32'(digit_ok), 32'h7);

      // blank digit2
      clear_counts();
      send_bits(24'h00064F, 8, 4);
      tick(10);
      check("blk_cnt", 32'(cnt_out), 32'hF13);
      check("blk_ok", 32'(digit_ok), 32'h3);
      check("blk_seg", 32'(seg_out), 32'h00064F);

      // partial frame then timeout: err 3 clk sync + 64 idle after the 5th pin edge
      clear_counts();
      send_bits(24'h7D5B66, 5, 4);
      tick(70);
      check("to_fe", 32'(fe_cnt), 32'd1);
      check("to_delay", 32'(err_cyc - last_rise), 32'd67);
      check("to_fv", 32'(fv_cnt), 32'd0);
      check("to_seg", 32'(seg_out), 32'h00064F);
      check("to_cnt", 32'(cnt_out), 32'hF13);
      clear_counts();
      send_bits(24'h3F064F, 8, 4);
      tick(10);
      check("after_to_fv", 32'(fv_cnt), 32'd1);
      check("after_to_cnt", 32'(cnt_out), 32'h013);
      check("after_to_ok", 32'(digit_ok), 32'h7);

      // edges 64 clk apart: 63 idle cycles between detected edges, no abort
      clear_counts();
      send_bits(24'h6D7F06, 8, 59);
      tick(10);
      check("gap_fe", 32'(fe_cnt), 32'd0);
      check("gap_fv", 32'(fv_cnt), 32'd1);
      check("gap_cnt", 32'(cnt_out), 32'h581);
      check("gap_seg", 32'(seg_out), 32'h6D7F06);

      // reset mid-frame, then a clean frame
      send_bits(24'hFFFFFF, 4, 4);
      reset = 1'b1;
      tick(2);
      check("mid_rst_seg", 32'(seg_out), 32'h0);
      check("mid_rst_ok", 32'(digit_ok), 32'h0);
      reset = 1'b0;
      tick(5);
      clear_counts();
      send_bits(24'h6D6F7F, 8, 4);
      tick(10);
      check("rr_fv", 32'(fv_cnt), 32'd1);
      check("rr_fe", 32'(fe_cnt), 32'd0);
      check("rr_seg", 32'(seg_out), 32'h6D6F7F);
      check("rr_cnt", 32'(cnt_out), 32'h598);
      check("rr_ok", 32'(digit_ok), 32'h7);

      check("never_both", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
